// File: rtl/cr_su_mc.sv
`default_nettype none
// ============================================================================
//  Module   : cr_su_mc
//  Purpose  : Multi-channel scheduler-update collector. Buffers each input
//             channel in its own FIFO, arbitrates round-robin and serialises
//             whole records onto a 64-bit stream output, LSB beat first.
//             Keeps per-channel accept/drop counters with strobed snapshots.
//  Revision : 1.0  initial release
// ============================================================================
module cr_su_mc #(
    parameter int N_CH  = 4,
    parameter int REC_W = 128,
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_drop_mode,
    input  logic [N_CH-1:0]         su_in_valid,
    input  logic [N_CH*REC_W-1:0]   su_in_data,
    output logic [N_CH-1:0]         su_ready,
    output logic                    ob_tvalid,
    input  logic                    ob_tready,
    output logic [63:0]             ob_tdata,
    output logic                    ob_tlast,
    output logic [$clog2(N_CH)-1:0] ob_tid,
    input  logic                    cnt_stb,
    output logic [N_CH*CNT_W-1:0]   acc_snap,
    output logic [N_CH*CNT_W-1:0]   drop_snap
);

    localparam int BEATS = REC_W / 64;
    localparam int ID_W  = $clog2(N_CH);
    localparam int AW    = $clog2(DEPTH);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // Per-channel FIFO storage and bookkeeping
    logic [REC_W-1:0]              mem [N_CH][DEPTH];
    logic [N_CH-1:0][AW-1:0]       wr_ptr;
    logic [N_CH-1:0][AW-1:0]       rd_ptr;
    logic [N_CH-1:0][AW:0]         count;
    logic [N_CH-1:0][REC_W-1:0]    in_rec;
    logic [N_CH-1:0]               full;
    logic [N_CH-1:0]               nonempty;
    logic [N_CH-1:0]               push;
    logic [N_CH-1:0]               discard;
    logic [N_CH-1:0]               pop;

    // Arbitration and output stage
    logic [ID_W-1:0]               last_grant;
    logic [ID_W-1:0]               grant_idx;
    logic [ID_W-1:0]               sel;
    int                            idx;
    logic                          found;
    logic                          load_ok;
    logic                          grant;
    logic [REC_W-1:0]              head_rec;
    logic [REC_W-1:0]              shreg;
    logic [BW-1:0]                 beat;

    // Statistics
    logic [N_CH-1:0][CNT_W-1:0]    acc;
    logic [N_CH-1:0][CNT_W-1:0]    drop;
    logic [N_CH-1:0][CNT_W-1:0]    acc_s;
    logic [N_CH-1:0][CNT_W-1:0]    drop_s;

    genvar gc;
    generate
        for (gc = 0; gc < N_CH; gc++) begin : g_ch
            assign in_rec[gc]   = su_in_data[gc*REC_W +: REC_W];
            assign full[gc]     = (count[gc] == FULL_CNT);
            assign nonempty[gc] = (count[gc] != '0);
            // Ready looks only at the registered count, so a same-cycle pop
            // never opens a slot for a same-cycle push.
            assign su_ready[gc] = cfg_drop_mode | ~full[gc];
            assign push[gc]     = su_in_valid[gc] & ~full[gc];
            assign discard[gc]  = su_in_valid[gc] & cfg_drop_mode & full[gc];
            assign pop[gc]      = grant & (grant_idx == ID_W'(gc));
            assign acc_snap[gc*CNT_W +: CNT_W]  = acc_s[gc];
            assign drop_snap[gc*CNT_W +: CNT_W] = drop_s[gc];
        end
    endgenerate

    // Round-robin search upward from the channel after the last grant
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        idx       = 0;
        sel       = '0;
        for (int i = 1; i <= N_CH; i++) begin
            idx = int'(last_grant) + i;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            sel = ID_W'(idx);
            if (!found && nonempty[sel]) begin
                found     = 1'b1;
                grant_idx = sel;
            end
        end
    end

    // A new record may load when the output is idle or its last beat leaves
    assign load_ok  = ~ob_tvalid | (ob_tready & ob_tlast);
    assign grant    = found & load_ok;
    assign head_rec = mem[grant_idx][rd_ptr[grant_idx]];
    assign ob_tdata = shreg[63:0];

    // FIFO pointer and occupancy tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (push[c]) begin
                    wr_ptr[c] <= wr_ptr[c] + AW'(1);
                end
                if (pop[c]) begin
                    rd_ptr[c] <= rd_ptr[c] + AW'(1);
                end
                case ({push[c], pop[c]})
                    2'b10:   count[c] <= count[c] + (AW+1)'(1);
                    2'b01:   count[c] <= count[c] - (AW+1)'(1);
                    default: count[c] <= count[c];
                endcase
            end
        end
    end

    // FIFO data storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (push[c]) begin
                mem[c][wr_ptr[c]] <= in_rec[c];
            end
        end
    end

    // Output shift register: load on grant, shift one beat per handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ob_tvalid  <= 1'b0;
            ob_tlast   <= 1'b0;
            ob_tid     <= '0;
            shreg      <= '0;
            beat       <= '0;
            last_grant <= ID_W'(N_CH - 1);
        end else if (grant) begin
            ob_tvalid  <= 1'b1;
            ob_tlast   <= (BEATS == 1);
            ob_tid     <= grant_idx;
            shreg      <= head_rec;
            beat       <= '0;
            last_grant <= grant_idx;
        end else if (ob_tvalid && ob_tready) begin
            if (ob_tlast) begin
                ob_tvalid <= 1'b0;
            end else begin
                shreg    <= shreg >> 64;
                beat     <= beat + BW'(1);
                ob_tlast <= ((int'(beat) + 2) == BEATS);
            end
        end
    end

    // Live counters with snapshot-and-restart; same-cycle events go live
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            drop   <= '0;
            acc_s  <= '0;
            drop_s <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (cnt_stb) begin
                    acc_s[c]  <= acc[c];
                    drop_s[c] <= drop[c];
                    acc[c]    <= CNT_W'(push[c]);
                    drop[c]   <= CNT_W'(discard[c]);
                end else begin
                    if (push[c]) begin
                        acc[c] <= acc[c] + CNT_W'(1);
                    end
                    if (discard[c] && (drop[c] != '1)) begin
                        drop[c] <= drop[c] + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cr_su_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cr_su_mc
//  Purpose  : Directed self-checking bench for cr_su_mc with a beat
//             scoreboard filled as records are sent and drained as the
//             output stream handshakes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cr_su_mc;

    localparam int N_CH  = 4;
    localparam int REC_W = 128;
    localparam int DEPTH = 4;
    localparam int CNT_W = 32;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    cfg_drop_mode;
    logic [N_CH-1:0]         su_in_valid;
    logic [N_CH*REC_W-1:0]   su_in_data;
    logic [N_CH-1:0]         su_ready;
    logic                    ob_tvalid;
    logic                    ob_tready;
    logic [63:0]             ob_tdata;
    logic                    ob_tlast;
    logic [1:0]              ob_tid;
    logic                    cnt_stb;
    logic [N_CH*CNT_W-1:0]   acc_snap;
    logic [N_CH*CNT_W-1:0]   drop_snap;

    typedef struct {
        logic [63:0] d;
        logic        l;
        logic [1:0]  id;
    } beat_t;

    beat_t exp_q[$];
    int    total    = 0;
    int    bad      = 0;
    int    cyc      = 0;
    int    hs_cnt   = 0;
    int    first_hs = 0;
    int    last_hs  = 0;

    cr_su_mc #(
        .N_CH  (N_CH),
        .REC_W (REC_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_drop_mode (cfg_drop_mode),
        .su_in_valid   (su_in_valid),
        .su_in_data    (su_in_data),
        .su_ready      (su_ready),
        .ob_tvalid     (ob_tvalid),
        .ob_tready     (ob_tready),
        .ob_tdata      (ob_tdata),
        .ob_tlast      (ob_tlast),
        .ob_tid        (ob_tid),
        .cnt_stb       (cnt_stb),
        .acc_snap      (acc_snap),
        .drop_snap     (drop_snap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [127:0] mkrec(input int c, input int k);
        return {32'hA5A50000 + 32'(c), 32'(k), 32'h5A5A0000 + 32'(k), 32'(c)};
    endfunction

    task automatic expect_rec(input int c, input logic [127:0] r);
        exp_q.push_back('{r[63:0],   1'b0, 2'(c)});
        exp_q.push_back('{r[127:64], 1'b1, 2'(c)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int c, input logic [127:0] r);
        su_in_data[c*REC_W +: REC_W] = r;
        su_in_valid[c] = 1'b1;
        tick();
        su_in_valid[c] = 1'b0;
    endtask

    task automatic strobe();
        cnt_stb = 1'b1;
        tick();
        cnt_stb = 1'b0;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        su_in_valid = '0;
        cnt_stb     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        hs_cnt = 0;
    endtask

    task automatic wait_drain(input int maxc);
        int n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            tick();
            n++;
        end
        check("drain_left", 128'(exp_q.size()), 128'd0);
    endtask

    // Output monitor: scoreboard compare on handshake, stability under stall
    task automatic monitor();
        logic        pstall = 1'b0;
        logic [63:0] hd = '0;
        logic        hl = 1'b0;
        logic [1:0]  hid = '0;
        beat_t       e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                pstall = 1'b0;
            end else begin
                if (pstall) begin
                    check("hold_valid", ob_tvalid, 1'b1);
                    check("hold_data", ob_tdata, hd);
                    check("hold_last", ob_tlast, hl);
                    check("hold_tid", ob_tid, hid);
                end
                if (ob_tvalid && ob_tready) begin
                    hs_cnt++;
                    if (hs_cnt == 1) first_hs = cyc;
                    last_hs = cyc;
                    check("beat_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("beat_data", ob_tdata, e.d);
                        check("beat_last", ob_tlast, e.l);
                        check("beat_tid", ob_tid, e.id);
                    end
                end
                pstall = ob_tvalid & ~ob_tready;
                hd     = ob_tdata;
                hl     = ob_tlast;
                hid    = ob_tid;
            end
        end
    endtask

    initial begin
        logic [127:0] r;
        rst_n         = 1'b0;
        cfg_drop_mode = 1'b0;
        su_in_valid   = '0;
        su_in_data    = '0;
        ob_tready     = 1'b1;
        cnt_stb       = 1'b0;

        fork
            monitor();
        join_none
        fork
            begin
                #100000;
                $display("FAIL timeout total=%0d bad=%0d", total, bad);
                $fatal(1, "simulation time limit reached");
            end
        join_none

        // Reset state
        do_reset();
        check("rst_ready", su_ready, 4'hF);
        check("rst_tvalid", ob_tvalid, 1'b0);
        check("rst_tdata", ob_tdata, 64'h0);
        check("rst_tlast", ob_tlast, 1'b0);
        check("rst_tid", ob_tid, 2'd0);
        check("rst_acc", acc_snap, '0);
        check("rst_drop", drop_snap, '0);

        // Single record on ch0, latency and beat order
        r = {64'h1111111111111111, 64'h2222222222222222};
        expect_rec(0, r);
        send(0, r);
        check("lat_edge_n", ob_tvalid, 1'b0);
        tick();
        check("lat_edge_n1", ob_tvalid, 1'b1);
        check("lat_beat0", ob_tdata, 64'h2222222222222222);
        wait_drain(10);

        // All four channels at once, twice: order 0..3, no bubbles
        do_reset();
        for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < N_CH; c++) begin
                su_in_data[c*REC_W +: REC_W] = mkrec(c, b);
                expect_rec(c, mkrec(c, b));
            end
            su_in_valid = '1;
            hs_cnt = 0;
            tick();
            su_in_valid = '0;
            wait_drain(20);
            check("burst_beats", hs_cnt, 8);
            check("burst_span", last_hs - first_hs, 7);
        end

        // ch2 record stalled two cycles on beat 0
        do_reset();
        r = mkrec(2, 7);
        expect_rec(2, r);
        send(2, r);
        tick();
        ob_tready = 1'b0;
        tick();
        tick();
        ob_tready = 1'b1;
        wait_drain(10);
        check("stall_beats", hs_cnt, 2);

        // Mode 0 backpressure: output parked on ch0, ch1 offers 6
        do_reset();
        cfg_drop_mode = 1'b0;
        ob_tready = 1'b0;
        expect_rec(0, mkrec(0, 0));
        send(0, mkrec(0, 0));
        tick();
        tick();
        for (int k = 0; k < 6; k++) begin
            su_in_data[REC_W +: REC_W] = mkrec(1, k);
            su_in_valid[1] = 1'b1;
            check("m0_ready", su_ready[1], k < 4);
            if (k < 4) expect_rec(1, mkrec(1, k));
            tick();
        end
        su_in_valid[1] = 1'b0;
        check("m0_ready_full", su_ready[1], 1'b0);
        ob_tready = 1'b1;
        wait_drain(30);
        strobe();
        check("m0_acc1", acc_snap[CNT_W +: CNT_W], 32'd4);
        check("m0_drop1", drop_snap[CNT_W +: CNT_W], 32'd0);

        // Mode 1 discard: same traffic, two records dropped
        do_reset();
        cfg_drop_mode = 1'b1;
        ob_tready = 1'b0;
        expect_rec(0, mkrec(0, 9));
        send(0, mkrec(0, 9));
        tick();
        tick();
        for (int k = 0; k < 6; k++) begin
            su_in_data[REC_W +: REC_W] = mkrec(1, 10 + k);
            su_in_valid[1] = 1'b1;
            check("m1_ready", su_ready[1], 1'b1);
            if (k < 4) expect_rec(1, mkrec(1, 10 + k));
            tick();
        end
        su_in_valid[1] = 1'b0;
        strobe();
        check("m1_acc1", acc_snap[CNT_W +: CNT_W], 32'd4);
        check("m1_drop1", drop_snap[CNT_W +: CNT_W], 32'd2);
        check("m1_acc0", acc_snap[0 +: CNT_W], 32'd1);
        ob_tready = 1'b1;
        wait_drain(30);
        cfg_drop_mode = 1'b0;

        // Strobe coincident with an accept on ch3
        do_reset();
        for (int k = 0; k < 5; k++) begin
            expect_rec(3, mkrec(3, k));
            send(3, mkrec(3, k));
            tick();
        end
        su_in_data[3*REC_W +: REC_W] = mkrec(3, 5);
        expect_rec(3, mkrec(3, 5));
        su_in_valid[3] = 1'b1;
        cnt_stb = 1'b1;
        check("stb_ready3", su_ready[3], 1'b1);
        tick();
        su_in_valid[3] = 1'b0;
        cnt_stb = 1'b0;
        check("stb_acc3_first", acc_snap[3*CNT_W +: CNT_W], 32'd5);
        wait_drain(20);
        strobe();
        check("stb_acc3_second", acc_snap[3*CNT_W +: CNT_W], 32'd1);

        // Reset in the middle of a record with three more queued
        do_reset();
        ob_tready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("rr_ready", su_ready[0], 1'b1);
            send(0, mkrec(0, 20 + k));
        end
        tick();
        strobe();
        check("rr_acc_before", acc_snap[0 +: CNT_W], 32'd4);
        check("rr_valid_before", ob_tvalid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rr_async_valid", ob_tvalid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        hs_cnt = 0;
        ob_tready = 1'b1;
        repeat (6) tick();
        check("rr_idle_beats", hs_cnt, 0);
        check("rr_idle_valid", ob_tvalid, 1'b0);
        check("rr_acc_snap", acc_snap, '0);
        check("rr_drop_snap", drop_snap, '0);
        expect_rec(1, mkrec(1, 30));
        send(1, mkrec(1, 30));
        wait_drain(10);
        check("rr_new_beats", hs_cnt, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
